// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on operands and result.
// Logic ops, ADD and SUB finish at the accept edge. Shifts move one bit per
// cycle and MUL is a shift-add loop running WIDTH cycles. Y and the N/Z/C/V
// flags are registered and stay stable in HOLD until the result is taken.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both 1, and a result is taken on a rising edge where out_valid
// and out_ready are both 1. in_ready is 1 only in IDLE and out_valid is 1 only
// in HOLD, so the earliest next accept comes two cycles after the previous one.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Negative,
  output logic             Zero,
  output logic             Overflow,
  output logic [1:0]       o_dbg_state
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int DW  = 2 * WIDTH;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOTA = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_sel;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_acc;
  logic [DW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_y;
  logic             r_c, r_n, r_z, r_v;
  logic             r_in_ready, r_out_valid;

  logic [SHW-1:0]   w_shamt;
  logic             w_is_shift;
  logic             w_is_mul;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_sc_y;
  logic             w_sc_c, w_sc_v;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_out;
  logic [DW-1:0]    w_acc_next;
  logic [WIDTH-1:0] w_fin_y;
  logic             w_fin_c;

  assign w_shamt    = B[SHW-1:0];
  assign w_is_shift = (sel == OP_SLL) || (sel == OP_SRL) || (sel == OP_SRA);
  assign w_is_mul   = (sel == OP_MUL);
  assign w_add      = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
  assign w_sub      = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

  // Result of the ops that complete at the accept edge (incl. zero-length shifts)
  always_comb begin
    w_sc_y = '0;
    w_sc_c = 1'b0;
    w_sc_v = 1'b0;
    case (sel)
      OP_AND:  w_sc_y = A & B;
      OP_OR:   w_sc_y = A | B;
      OP_NOTA: w_sc_y = ~A;
      OP_NOR:  w_sc_y = ~(A | B);
      OP_XOR:  w_sc_y = A ^ B;
      OP_NAND: w_sc_y = ~(A & B);
      OP_ADD: begin
        w_sc_y = w_add[WIDTH-1:0];
        w_sc_c = w_add[WIDTH];
        w_sc_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_y = w_sub[WIDTH-1:0];
        w_sc_c = w_sub[WIDTH];
        w_sc_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL, OP_SRL, OP_SRA: w_sc_y = A;
      default: ;
    endcase
  end

  // One-bit shift step of the work register and the bit that falls out
  always_comb begin
    w_sh_next = r_work;
    w_sh_out  = 1'b0;
    case (r_sel)
      OP_SLL: begin
        w_sh_next = {r_work[WIDTH-2:0], 1'b0};
        w_sh_out  = r_work[WIDTH-1];
      end
      OP_SRL: begin
        w_sh_next = {1'b0, r_work[WIDTH-1:1]};
        w_sh_out  = r_work[0];
      end
      OP_SRA: begin
        w_sh_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
        w_sh_out  = r_work[0];
      end
      default: ;
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_fin_y    = (r_sel == OP_MUL) ? w_acc_next[WIDTH-1:0] : w_sh_next;
  assign w_fin_c    = (r_sel == OP_MUL) ? (|w_acc_next[DW-1:WIDTH]) : w_sh_out;

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_y         <= '0;
      r_c         <= 1'b0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_v         <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sel      <= sel;
            r_in_ready <= 1'b0;
            if (w_is_mul) begin
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, A};
              r_mplier <= B;
              r_cnt    <= CW'(WIDTH);
              r_state  <= S_EXEC;
            end else if (w_is_shift && (w_shamt != '0)) begin
              r_work  <= A;
              r_cnt   <= {1'b0, w_shamt};
              r_state <= S_EXEC;
            end else begin
              r_y         <= w_sc_y;
              r_c         <= w_sc_c;
              r_v         <= w_sc_v;
              r_n         <= w_sc_y[WIDTH-1];
              r_z         <= (w_sc_y == '0);
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end
        end
        S_EXEC: begin
          r_work   <= w_sh_next;
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_y         <= w_fin_y;
            r_c         <= w_fin_c;
            r_v         <= 1'b0;
            r_n         <= w_fin_y[WIDTH-1];
            r_z         <= (w_fin_y == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign Y           = r_y;
  assign Cout        = r_c;
  assign Negative    = r_n;
  assign Zero        = r_z;
  assign Overflow    = r_v;
  assign o_dbg_state = r_state;
endmodule
